// File: rtl/jp_multi_if.sv
// CPU bus and shared pad wiring for the jp_multi joypad controller.
// The CPU/bench side uses the master modport; the controller uses the slave modport.
interface jp_multi_if #(
  parameter int NUM_PADS = 2
);
  logic                wr;
  logic [15:0]         addr;
  logic [7:0]          din;
  logic [7:0]          dout;
  logic [NUM_PADS-1:0] jp_data;
  logic                jp_clk;
  logic                jp_latch;

  modport master (
    output wr, addr, din, jp_data,
    input  dout, jp_clk, jp_latch
  );

  modport slave (
    input  wr, addr, din, jp_data,
    output dout, jp_clk, jp_latch
  );
endinterface

// File: rtl/jp_multi.sv
// Joypad controller: polls 2 or 4 serial pads and serves NES-style reads of 0x4016/0x4017.
// Optional JP_DEBOUNCE_EN: a pad's state only updates when two consecutive polls agree.
module jp_multi #(
  parameter int NUM_PADS    = 2,
  parameter int CLK_DIV     = 250,
  parameter int POLL_CYCLES = 833333
) (
  input  logic        clk,
  input  logic        nres,
  jp_multi_if.slave   bus
);

  localparam int POLL_W = $clog2(POLL_CYCLES);
  localparam int PH_W   = $clog2(2 * CLK_DIV);
  localparam int SR_W   = (NUM_PADS == 4) ? 24 : 8;

  localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_CYCLES - 1);
  localparam logic [PH_W-1:0]   LATCH_LAST = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]   HALF_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [15:0]       ADDR_P0    = 16'h4016;
  localparam logic [15:0]       ADDR_P1    = 16'h4017;

  // The Four Score shifts its 0x10/0x20 signature MSB first, so it sits bit-reversed here.
  localparam logic [7:0] SIG_P0 = 8'b0000_1000;
  localparam logic [7:0] SIG_P1 = 8'b0000_0100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CLK_HI,
    S_CLK_LO,
    S_UPDATE
  } state_e;

  state_e                        state_q, state_d;
  logic [POLL_W-1:0]             poll_cnt_q, poll_cnt_d;
  logic [PH_W-1:0]               phase_q, phase_d;
  logic [2:0]                    bit_idx_q, bit_idx_d;
  logic [NUM_PADS-1:0][7:0]      poll_q, poll_d;
  logic [NUM_PADS-1:0][7:0]      btn_q, btn_d;
`ifdef JP_DEBOUNCE_EN
  logic [NUM_PADS-1:0][7:0]      prev_q, prev_d;
`endif
  logic                          jp_clk_q, jp_clk_d;
  logic                          jp_latch_q, jp_latch_d;
  logic                          strobe_q, strobe_d;
  logic [1:0][SR_W-1:0]          sr_q, sr_d;
  logic [1:0][SR_W-1:0]          reload;
  logic [1:0]                    rd_prev_q;
  logic [1:0]                    acc;
  logic                          unused_din;

  assign unused_din = ^bus.din[7:1];

  generate
    if (NUM_PADS == 4) begin : g_four_score
      assign reload[0] = {SIG_P0, btn_q[2], btn_q[0]};
      assign reload[1] = {SIG_P1, btn_q[3], btn_q[1]};
    end else begin : g_two_pads
      assign reload[0] = btn_q[0];
      assign reload[1] = btn_q[1];
    end
  endgenerate

  assign acc[0] = !bus.wr && (bus.addr == ADDR_P0);
  assign acc[1] = !bus.wr && (bus.addr == ADDR_P1);

  // Poll sequencer and CPU-side next state.
  // NOTE: every variable gets a default at the top of always_comb so no path leaves a latch.
  always_comb begin
    state_d    = state_q;
    poll_cnt_d = (poll_cnt_q == POLL_LAST) ? '0 : poll_cnt_q + POLL_W'(1);
    phase_d    = phase_q;
    bit_idx_d  = bit_idx_q;
    poll_d     = poll_q;
    btn_d      = btn_q;
`ifdef JP_DEBOUNCE_EN
    prev_d     = prev_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (poll_cnt_q == POLL_LAST) begin
          state_d = S_LATCH;
          phase_d = '0;
        end
      end
      S_LATCH: begin
        if (phase_q == LATCH_LAST) begin
          for (int p = 0; p < NUM_PADS; p++) poll_d[p][0] = ~bus.jp_data[p];
          phase_d   = '0;
          bit_idx_d = 3'd1;
          state_d   = S_CLK_HI;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_CLK_HI: begin
        if (phase_q == HALF_LAST) begin
          phase_d = '0;
          state_d = S_CLK_LO;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_CLK_LO: begin
        if (phase_q == HALF_LAST) begin
          for (int p = 0; p < NUM_PADS; p++) poll_d[p][bit_idx_q] = ~bus.jp_data[p];
          phase_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = S_UPDATE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            state_d   = S_CLK_HI;
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_UPDATE: begin
        for (int p = 0; p < NUM_PADS; p++) begin
`ifdef JP_DEBOUNCE_EN
          if (poll_q[p] == prev_q[p]) btn_d[p] = poll_q[p];
          prev_d[p] = poll_q[p];
`else
          btn_d[p] = poll_q[p];
`endif
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    jp_clk_d   = (state_d == S_CLK_HI);
    jp_latch_d = (state_d == S_LATCH);

    strobe_d = (bus.wr && (bus.addr == ADDR_P0)) ? bus.din[0] : strobe_q;

    // A read shifts its port once, when the access ends; strobe overrides any shift.
    for (int k = 0; k < 2; k++) begin
      if (strobe_q)                       sr_d[k] = reload[k];
      else if (rd_prev_q[k] && !acc[k])   sr_d[k] = {1'b1, sr_q[k][SR_W-1:1]};
      else                                sr_d[k] = sr_q[k];
    end
  end

  always_comb begin
    bus.dout = 8'h00;
    if (acc[0])      bus.dout = {7'b0, sr_q[0][0]};
    else if (acc[1]) bus.dout = {7'b0, sr_q[1][0]};
  end

  assign bus.jp_clk   = jp_clk_q;
  assign bus.jp_latch = jp_latch_q;

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  // NOTE: the per-pad byte arrays are a handful of flops, so they take reset like the rest.
  always_ff @(posedge clk) begin
    if (!nres) begin
      state_q    <= S_IDLE;
      poll_cnt_q <= '0;
      phase_q    <= '0;
      bit_idx_q  <= '0;
      poll_q     <= '0;
      btn_q      <= '0;
`ifdef JP_DEBOUNCE_EN
      prev_q     <= '0;
`endif
      jp_clk_q   <= 1'b0;
      jp_latch_q <= 1'b0;
      strobe_q   <= 1'b0;
      sr_q       <= '1;
      rd_prev_q  <= '0;
    end else begin
      state_q    <= state_d;
      poll_cnt_q <= poll_cnt_d;
      phase_q    <= phase_d;
      bit_idx_q  <= bit_idx_d;
      poll_q     <= poll_d;
      btn_q      <= btn_d;
`ifdef JP_DEBOUNCE_EN
      prev_q     <= prev_d;
`endif
      jp_clk_q   <= jp_clk_d;
      jp_latch_q <= jp_latch_d;
      strobe_q   <= strobe_d;
      sr_q       <= sr_d;
      rd_prev_q  <= acc;
    end
  end

endmodule
